// File: rtl/cell_decoder.sv
// -----------------------------------------------------------------------------
// cell_decoder
//   Snoops the per-pixel plot bus heading to the VGA adapter and captures every
//   write that lands inside a 16x16 cell, anchored at a programmed origin, into
//   a 1-bit bitmap. When done_in arrives, the block scans the bitmap one bit per
//   cycle in row-major order. It then reports the pixel count, the row and
//   column occupancy masks and the out-of-window write count. Game logic uses
//   these results to identify which glyph was drawn.
//
//   Parameter BG_COLOUR  : erase colour. A write of this colour clears the bit;
//                          a write of any other colour sets it.
//   Optional feature macro CELL_DECODER_BBOX_EN : adds the bounding-box outputs.
//
// Ports
//   clk, reset_n            clock; asynchronous active-low reset
//   start                   latch ox/oy, clear the bitmap, begin capture
//   ox[7:0], oy[6:0]        cell origin, sampled on start
//   x[7:0], y[6:0]          plot bus coordinates
//   colour[2:0], plot       plot bus colour and write strobe
//   done_in                 end of symbol; begin the scan
//   busy                    high in CAPTURE or SCAN
//   valid                   one-cycle pulse when the results update
//   pix_count[8:0]          number of set bits, 0..256
//   row_mask[15:0]          bit r is set if row r holds any pixel
//   col_mask[15:0]          bit c is set if column c holds any pixel
//   oob_count[7:0]          out-of-window writes during capture, saturates at 255
//   bbox_{x,y}{min,max}     (CELL_DECODER_BBOX_EN only) 4-bit bounding box
// -----------------------------------------------------------------------------
module cell_decoder #(
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  ox,
  input  logic [6:0]  oy,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        plot,
  input  logic        done_in,
  output logic        busy,
  output logic        valid,
  output logic [8:0]  pix_count,
  output logic [15:0] row_mask,
  output logic [15:0] col_mask,
`ifdef CELL_DECODER_BBOX_EN
  output logic [3:0]  bbox_xmin,
  output logic [3:0]  bbox_xmax,
  output logic [3:0]  bbox_ymin,
  output logic [3:0]  bbox_ymax,
`endif
  output logic [7:0]  oob_count
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SCAN, S_DONE} state_t;

  state_t        r_state, w_next_state;
  logic [7:0]    r_ox;
  logic [6:0]    r_oy;
  logic [255:0]  r_bitmap;
  logic [7:0]    r_idx;
  logic [8:0]    r_acc_cnt;
  logic [15:0]   r_acc_row, r_acc_col;
  logic [7:0]    r_oob;

  // The subtraction wraps, so a coordinate left of or above the origin becomes
  // a large offset and falls outside the window.
  logic [7:0]    w_dx;
  logic [6:0]    w_dy;
  logic          w_in_win;
  logic [7:0]    w_wr_idx;
  logic          w_scan_bit;
  logic [3:0]    w_row, w_col;
  logic [8:0]    w_cnt_nxt;
  logic [15:0]   w_row_nxt, w_col_nxt;

  assign w_dx       = x - r_ox;
  assign w_dy       = y - r_oy;
  assign w_in_win   = (w_dx < 8'd16) && (w_dy < 7'd16);
  assign w_wr_idx   = {w_dy[3:0], w_dx[3:0]};
  assign w_scan_bit = r_bitmap[r_idx];
  assign w_row      = r_idx[7:4];
  assign w_col      = r_idx[3:0];
  assign w_cnt_nxt  = r_acc_cnt + {8'd0, w_scan_bit};
  assign w_row_nxt  = r_acc_row | (16'(w_scan_bit) << w_row);
  assign w_col_nxt  = r_acc_col | (16'(w_scan_bit) << w_col);

  assign busy      = (r_state == S_CAPTURE) || (r_state == S_SCAN);
  assign valid     = (r_state == S_DONE);
  assign oob_count = r_oob;

`ifdef CELL_DECODER_BBOX_EN
  logic [3:0] r_acc_xmin, r_acc_xmax, r_acc_ymin, r_acc_ymax;
  logic [3:0] w_xmin_nxt, w_xmax_nxt, w_ymin_nxt, w_ymax_nxt;

  assign w_xmin_nxt = (w_scan_bit && (w_col < r_acc_xmin)) ? w_col : r_acc_xmin;
  assign w_xmax_nxt = (w_scan_bit && (w_col > r_acc_xmax)) ? w_col : r_acc_xmax;
  assign w_ymin_nxt = (w_scan_bit && (w_row < r_acc_ymin)) ? w_row : r_acc_ymin;
  assign w_ymax_nxt = (w_scan_bit && (w_row > r_acc_ymax)) ? w_row : r_acc_ymax;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  // NOTE: assign a default before the case statement so that no path leaves
  // w_next_state unassigned. An unassigned path would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_CAPTURE;
      S_CAPTURE: begin
        if (start)        w_next_state = S_CAPTURE;
        else if (done_in) w_next_state = S_SCAN;
      end
      S_SCAN:    if (r_idx == 8'hFF) w_next_state = S_DONE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Datapath: capture, scan accumulation and result registers.
  // NOTE: the bitmap sits in flops, not RAM, so it can be reset asynchronously
  // together with the other state. This also makes the whole-cell clear on
  // start a single-cycle operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ox      <= '0;
      r_oy      <= '0;
      r_bitmap  <= '0;
      r_idx     <= '0;
      r_acc_cnt <= '0;
      r_acc_row <= '0;
      r_acc_col <= '0;
      r_oob     <= '0;
      pix_count <= '0;
      row_mask  <= '0;
      col_mask  <= '0;
`ifdef CELL_DECODER_BBOX_EN
      r_acc_xmin <= '0;
      r_acc_xmax <= '0;
      r_acc_ymin <= '0;
      r_acc_ymax <= '0;
      bbox_xmin  <= '0;
      bbox_xmax  <= '0;
      bbox_ymin  <= '0;
      bbox_ymax  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_CAPTURE: begin
          if (start) begin
            r_ox     <= ox;
            r_oy     <= oy;
            r_bitmap <= '0;
            r_oob    <= '0;
          end else if (r_state == S_CAPTURE) begin
            // A plot in the same cycle as done_in still lands before the scan.
            if (plot) begin
              if (w_in_win)           r_bitmap[w_wr_idx] <= (colour != BG_COLOUR);
              else if (r_oob != 8'hFF) r_oob <= r_oob + 8'd1;
            end
            if (done_in) begin
              r_idx     <= '0;
              r_acc_cnt <= '0;
              r_acc_row <= '0;
              r_acc_col <= '0;
`ifdef CELL_DECODER_BBOX_EN
              r_acc_xmin <= 4'hF;
              r_acc_xmax <= 4'h0;
              r_acc_ymin <= 4'hF;
              r_acc_ymax <= 4'h0;
`endif
            end
          end
        end
        S_SCAN: begin
          r_idx     <= r_idx + 8'd1;
          r_acc_cnt <= w_cnt_nxt;
          r_acc_row <= w_row_nxt;
          r_acc_col <= w_col_nxt;
`ifdef CELL_DECODER_BBOX_EN
          r_acc_xmin <= w_xmin_nxt;
          r_acc_xmax <= w_xmax_nxt;
          r_acc_ymin <= w_ymin_nxt;
          r_acc_ymax <= w_ymax_nxt;
`endif
          // The results include the last bit, so they are visible in the
          // same cycle that valid is high.
          if (r_idx == 8'hFF) begin
            pix_count <= w_cnt_nxt;
            row_mask  <= w_row_nxt;
            col_mask  <= w_col_nxt;
`ifdef CELL_DECODER_BBOX_EN
            bbox_xmin <= w_xmin_nxt;
            bbox_xmax <= w_xmax_nxt;
            bbox_ymin <= w_ymin_nxt;
            bbox_ymax <= w_ymax_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_decoder.sv
module tb_cell_decoder;

  logic        clk = 1'b0;
  logic        reset_n, start, plot, done_in;
  logic [7:0]  ox, x;
  logic [6:0]  oy, y;
  logic [2:0]  colour;
  logic        busy, valid;
  logic [8:0]  pix_count;
  logic [15:0] row_mask, col_mask;
  logic [7:0]  oob_count;
`ifdef CELL_DECODER_BBOX_EN
  logic [3:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
`endif

  cell_decoder dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ox(ox), .oy(oy),
    .x(x), .y(y), .colour(colour), .plot(plot), .done_in(done_in),
    .busy(busy), .valid(valid), .pix_count(pix_count),
    .row_mask(row_mask), .col_mask(col_mask),
`ifdef CELL_DECODER_BBOX_EN
    .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
`endif
    .oob_count(oob_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the cell as a plain array of pixels plus a counter.
  bit  m_bm [256];
  int  m_oob;
  int  m_ox, m_oy;
  bit  m_cap;

  task automatic model_clear();
    foreach (m_bm[i]) m_bm[i] = 1'b0;
    m_oob = 0;
  endtask

  task automatic model_plot(input int px, input int py, input int pc);
    int dx, dy;
    if (!m_cap) return;
    dx = (px - m_ox + 256) % 256;
    dy = (py - m_oy + 128) % 128;
    if (dx < 16 && dy < 16) m_bm[dy * 16 + dx] = (pc != 0);
    else if (m_oob < 255)   m_oob++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; plot = 0; done_in = 0;
    ox = 0; oy = 0; x = 0; y = 0; colour = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    m_cap = 0;
    model_clear();
    tick(); tick();
    reset_n = 1;
    tick();
  endtask

  task automatic do_start(input int sx, input int sy);
    start = 1; ox = 8'(sx); oy = 7'(sy);
    tick();
    start = 0;
    m_ox = sx; m_oy = sy; m_cap = 1;
    model_clear();
  endtask

  task automatic do_plot(input int px, input int py, input int pc);
    plot = 1; x = 8'(px); y = 7'(py); colour = 3'(pc);
    model_plot(px, py, pc);
    tick();
    plot = 0;
  endtask

  // Issues done_in, optionally with a plot in the same cycle. It can also drive
  // start/plot/done_in during the scan, which must be ignored. It then waits
  // for valid and checks latency and all results against the model.
  task automatic finish(input string tag, input bit noise, input bit pd,
                        input int px, input int py, input int pc);
    int n;
    int e_cnt;
    logic [15:0] e_row, e_col;
    int xmin, xmax, ymin, ymax;
    if (pd) begin
      plot = 1; x = 8'(px); y = 7'(py); colour = 3'(pc);
      model_plot(px, py, pc);
    end
    done_in = 1;
    tick();
    done_in = 0; plot = 0;
    m_cap = 0;
    n = 1;
    check({tag, "_busy_scan"}, busy, 1);
    if (noise) begin
      start = 1; plot = 1; done_in = 1; ox = 8'(m_ox + 3); oy = 7'(m_oy + 3);
      x = 8'(m_ox); y = 7'(m_oy); colour = 3'd7;
      tick(); n++;
      start = 0; plot = 0; done_in = 0;
      x = 8'(m_ox + 5); y = 7'(m_oy + 5); plot = 1;
      tick(); n++;
      plot = 0;
    end
    while (valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 257);
    e_cnt = 0; e_row = 0; e_col = 0;
    xmin = 15; xmax = 0; ymin = 15; ymax = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (m_bm[r * 16 + c]) begin
          e_cnt++;
          e_row[r] = 1'b1;
          e_col[c] = 1'b1;
          if (c < xmin) xmin = c;
          if (c > xmax) xmax = c;
          if (r < ymin) ymin = r;
          if (r > ymax) ymax = r;
        end
    check({tag, "_pix_count"}, pix_count, e_cnt);
    check({tag, "_row_mask"}, row_mask, e_row);
    check({tag, "_col_mask"}, col_mask, e_col);
    check({tag, "_oob_count"}, oob_count, m_oob);
    check({tag, "_busy_done"}, busy, 0);
`ifdef CELL_DECODER_BBOX_EN
    check({tag, "_xmin"}, bbox_xmin, xmin);
    check({tag, "_xmax"}, bbox_xmax, xmax);
    check({tag, "_ymin"}, bbox_ymin, ymin);
    check({tag, "_ymax"}, bbox_ymax, ymax);
`endif
    tick();
    check({tag, "_valid_pulse"}, valid, 0);
  endtask

  initial begin
    int nv;
    reset_n = 1;
    idle_inputs();
    #2;
    do_reset();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_pix", pix_count, 0);
    check("rst_row", row_mask, 0);
    check("rst_col", col_mask, 0);
    check("rst_oob", oob_count, 0);

    // Two corner pixels
    do_start(40, 30);
    check("start_busy", busy, 1);
    do_plot(40, 30, 3);
    do_plot(55, 45, 3);
    finish("corners", 0, 0, 0, 0, 0);
    check("corners_pix_const", pix_count, 2);
    check("corners_row_const", row_mask, 16'h8001);

    // Just-outside writes
    do_start(40, 30);
    do_plot(39, 30, 3);
    do_plot(56, 30, 3);
    do_plot(40, 46, 3);
    finish("oob3", 0, 0, 0, 0, 0);
    check("oob3_const", oob_count, 3);

    // Erase, then a double write
    do_start(40, 30);
    do_plot(42, 33, 3);
    do_plot(42, 33, 0);
    finish("erase", 0, 0, 0, 0, 0);
    do_start(40, 30);
    do_plot(42, 33, 5);
    do_plot(42, 33, 6);
    finish("double", 0, 0, 0, 0, 0);

    // Full cell, saturating oob counter
    do_start(40, 30);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        do_plot(40 + c, 30 + r, 5);
    for (int i = 0; i < 300; i++) do_plot(60 + (i % 7), 30 + (i % 20), 2);
    finish("full", 0, 0, 0, 0, 0);
    check("full_pix_const", pix_count, 256);
    check("full_oob_const", oob_count, 255);

    // Plot together with done_in; start/plot/done_in ignored during the scan
    do_start(40, 30);
    finish("plotdone", 1, 1, 41, 31, 4);
    check("plotdone_pix_const", pix_count, 1);

    // Reset at scan index 100
    do_start(40, 30);
    do_plot(45, 35, 1);
    done_in = 1;
    tick();
    done_in = 0;
    for (int i = 0; i < 100; i++) tick();
    reset_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check("midrst_pix", pix_count, 0);
    check("midrst_row", row_mask, 0);
    check("midrst_col", col_mask, 0);
    check("midrst_oob", oob_count, 0);
    m_cap = 0;
    model_clear();
    tick();
    reset_n = 1;
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (valid === 1'b1) nv++;
    end
    check("midrst_no_valid", nv, 0);

    // Fresh run after the reset; its pixels give a 2/10/3/10 bounding box
    do_start(40, 30);
    do_plot(42, 33, 1);
    do_plot(50, 40, 1);
    finish("fresh", 0, 0, 0, 0, 0);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      int np;
      int px, py;
      do_start($urandom_range(0, 255), $urandom_range(0, 127));
      np = $urandom_range(0, 80);
      for (int i = 0; i < np; i++) begin
        if ($urandom_range(0, 39) == 0) begin
          do_start($urandom_range(0, 255), $urandom_range(0, 127));
        end else begin
          if ($urandom_range(0, 3) != 0) begin
            px = (m_ox + $urandom_range(0, 19)) % 256;
            py = (m_oy + $urandom_range(0, 19)) % 128;
          end else begin
            px = $urandom_range(0, 255);
            py = $urandom_range(0, 127);
          end
          do_plot(px, py, $urandom_range(0, 7));
        end
      end
      px = (m_ox + $urandom_range(0, 15)) % 256;
      py = (m_oy + $urandom_range(0, 15)) % 128;
      finish($sformatf("rnd%0d", t), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), px, py, $urandom_range(0, 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
